ram_bist: RTL and testbench

Built-in self-test initiator for the 8-bit single-port RAM. On `start` it drives the RAM's `address`/`write_en`/`data_in` port through a three-element march test and checks the RAM's `data_out`. It reports `pass`, or the first failing address and the data read there. It sits beside the RAM, muxed onto its port by the integrating block while `busy` is high.

---
 rtl/ram_bist_if.sv | 27 ++
 rtl/ram_bist.sv | 168 ++++++++++++++++
 tb/tb_ram_bist.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// Bundle between the RAM BIST initiator and its surroundings: test control,
// result reporting and the drive/return lines of the RAM port.
interface ram_bist_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();
   logic              start;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_write_en;
   logic [DATA_W-1:0] ram_data_in;
   logic [DATA_W-1:0] ram_data_out;

   modport master (
      input  start, ram_data_out,
      output busy, done, pass, fail_addr, fail_data, ram_address, ram_write_en, ram_data_in
   );

   modport slave (
      output start, ram_data_out,
      input  busy, done, pass, fail_addr, fail_data, ram_address, ram_write_en, ram_data_in
   );
endinterface

// File: rtl/ram_bist.sv
// March-test BIST initiator for a single-port synchronous RAM:
// up-write PATTERN, up read/compare/write ~PATTERN, down read/compare ~PATTERN.
module ram_bist #(
   parameter int              ADDR_W  = 8,
   parameter int              DATA_W  = 8,
   parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
   input  logic        clk,
   input  logic        reset,
   ram_bist_if.master  bist
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StWUp     = 3'd1;
   localparam logic [2:0] StRwUpRd  = 3'd2;
   localparam logic [2:0] StRwUpCmp = 3'd3;
   localparam logic [2:0] StRDnRd   = 3'd4;
   localparam logic [2:0] StRDnCmp  = 3'd5;
   localparam logic [2:0] StDone    = 3'd6;

   localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_din;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [DATA_W-1:0] r_fail_data;

   logic [2:0]        w_state_d;
   logic [ADDR_W-1:0] w_addr_d;
   logic              w_we_d;
   logic [DATA_W-1:0] w_din_d;
   logic              w_busy_d;
   logic              w_done_d;
   logic              w_pass_d;
   logic [ADDR_W-1:0] w_fail_addr_d;
   logic [DATA_W-1:0] w_fail_data_d;
   logic [DATA_W-1:0] w_expect;
   logic              w_match;

   assign w_expect = (r_state == StRwUpCmp) ? PATTERN : ~PATTERN;
   assign w_match  = (bist.ram_data_out == w_expect);

   always_comb begin
      w_state_d     = r_state;
      w_addr_d      = r_addr;
      w_we_d        = 1'b0;
      w_din_d       = '0;
      w_busy_d      = r_busy;
      w_done_d      = 1'b0;
      w_pass_d      = r_pass;
      w_fail_addr_d = r_fail_addr;
      w_fail_data_d = r_fail_data;
      case (r_state)
         StIdle: begin
            w_addr_d = '0;
            if (bist.start) begin
               w_state_d     = StWUp;
               w_we_d        = 1'b1;
               w_din_d       = PATTERN;
               w_busy_d      = 1'b1;
               w_pass_d      = 1'b0;
               w_fail_addr_d = '0;
               w_fail_data_d = '0;
            end
         end
         StWUp: begin
            if (r_addr == AddrMax) begin
               w_state_d = StRwUpRd;
               w_addr_d  = '0;
            end else begin
               w_addr_d = r_addr + ADDR_W'(1);
               w_we_d   = 1'b1;
               w_din_d  = PATTERN;
            end
         end
         StRwUpRd: begin
            // Write enable is armed here and gated by the compare result in the next cycle.
            w_state_d = StRwUpCmp;
            w_we_d    = 1'b1;
            w_din_d   = ~PATTERN;
         end
         StRwUpCmp: begin
            if (!w_match) begin
               w_state_d     = StDone;
               w_addr_d      = '0;
               w_done_d      = 1'b1;
               w_fail_addr_d = r_addr;
               w_fail_data_d = bist.ram_data_out;
            end else if (r_addr == AddrMax) begin
               w_state_d = StRDnRd;
               w_addr_d  = AddrMax;
            end else begin
               w_state_d = StRwUpRd;
               w_addr_d  = r_addr + ADDR_W'(1);
            end
         end
         StRDnRd: begin
            w_state_d = StRDnCmp;
         end
         StRDnCmp: begin
            if (!w_match) begin
               w_state_d     = StDone;
               w_addr_d      = '0;
               w_done_d      = 1'b1;
               w_fail_addr_d = r_addr;
               w_fail_data_d = bist.ram_data_out;
            end else if (r_addr == '0) begin
               w_state_d = StDone;
               w_done_d  = 1'b1;
               w_pass_d  = 1'b1;
            end else begin
               w_state_d = StRDnRd;
               w_addr_d  = r_addr - ADDR_W'(1);
            end
         end
         StDone: begin
            w_state_d = StIdle;
            w_addr_d  = '0;
            w_busy_d  = 1'b0;
         end
         default: begin
            w_state_d = StIdle;
            w_addr_d  = '0;
            w_busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_din       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else begin
         r_state     <= w_state_d;
         r_addr      <= w_addr_d;
         r_we        <= w_we_d;
         r_din       <= w_din_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_pass      <= w_pass_d;
         r_fail_addr <= w_fail_addr_d;
         r_fail_data <= w_fail_data_d;
      end
   end

   assign bist.ram_address  = r_addr;
   assign bist.ram_data_in  = r_din;
   // A mismatching compare suppresses the write-back of ~PATTERN.
   assign bist.ram_write_en = r_we & ((r_state != StRwUpCmp) | w_match);
   assign bist.busy         = r_busy;
   assign bist.done         = r_done;
   assign bist.pass         = r_pass;
   assign bist.fail_addr    = r_fail_addr;
   assign bist.fail_data    = r_fail_data;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: ideal and faulty synchronous RAM models,
// mid-run reset and ignored/accepted start pulses.
module tb_ram_bist;

   logic clk;
   logic reset;

   ram_bist_if #(.ADDR_W(8), .DATA_W(8)) bif ();

   ram_bist #(.ADDR_W(8), .DATA_W(8), .PATTERN(8'h55)) dut (
      .clk   (clk),
      .reset (reset),
      .bist  (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 0 ideal, 1 addr 0x10 bit0 stuck-0, 2 addr 0x20 bit1 stuck-1, 3 address bit7 ignored
   int         fault_mode;
   logic [7:0] mem [256];
   logic [7:0] rd_q;

   function automatic logic [7:0] ram_idx(input logic [7:0] a);
      return (fault_mode == 3) ? {1'b0, a[6:0]} : a;
   endfunction

   function automatic logic [7:0] ram_wdata(input logic [7:0] a, input logic [7:0] d);
      logic [7:0] r;
      r = d;
      if (fault_mode == 1 && a == 8'h10) r[0] = 1'b0;
      if (fault_mode == 2 && a == 8'h20) r[1] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      if (bif.ram_write_en) mem[ram_idx(bif.ram_address)] <= ram_wdata(bif.ram_address,
                                                                       bif.ram_data_in);
      else rd_q <= mem[ram_idx(bif.ram_address)];
   end

   assign bif.ram_data_out = rd_q;

   int n_tests;
   int n_fail;

   int          g_done_cyc;
   int          g_done_cnt;
   logic [17:0] g_c1;
   logic [16:0] g_drv_done;
   logic        g_busy_p1;
   logic        g_busy_p2;
   logic        g_pass_p2;

   task automatic do_reset();
      bif.start = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Start at the edge E0 after the current negedge; cycle k is sampled at the k-th negedge.
   task automatic run(input int max_cyc, input int x1, input int x2, input int x3);
      g_done_cyc = 0;
      g_done_cnt = 0;
      g_c1       = '0;
      g_drv_done = '1;
      g_busy_p1  = 1'bx;
      g_busy_p2  = 1'bx;
      g_pass_p2  = 1'bx;
      @(negedge clk);
      bif.start = 1'b1;
      for (int k = 1; k <= max_cyc; k++) begin
         @(negedge clk);
         bif.start = (k == x1) || (k == x2) || (k == x3);
         if (k == 1) g_c1 = {bif.busy, bif.ram_address, bif.ram_write_en, bif.ram_data_in};
         if (g_done_cyc != 0 && k == g_done_cyc + 1) g_busy_p1 = bif.busy;
         if (g_done_cyc != 0 && k == g_done_cyc + 2) begin
            g_busy_p2 = bif.busy;
            g_pass_p2 = bif.pass;
         end
         if (bif.done) begin
            g_done_cnt++;
            if (g_done_cyc == 0) begin
               g_done_cyc = k;
               g_drv_done = {bif.ram_address, bif.ram_write_en, bif.ram_data_in};
            end
         end
      end
      bif.start = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bif.start = 1'b0;
      #1;
      n_tests++;
      if ({bif.busy, bif.done, bif.pass, bif.fail_addr, bif.fail_data, bif.ram_address,
           bif.ram_write_en, bif.ram_data_in} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fa=%h fd=%h a=%h we=%b d=%h, want all 0",
                  bif.busy, bif.done, bif.pass, bif.fail_addr, bif.fail_data, bif.ram_address,
                  bif.ram_write_en, bif.ram_data_in);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bif.busy, bif.done, bif.ram_write_en} !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b done=%b we=%b, want 0 0 0",
                  bif.busy, bif.done, bif.ram_write_en);
      end
   endtask

   task automatic test_pass();
      int bad;
      fault_mode = 0;
      do_reset();
      run(1290, 0, 0, 0);
      n_tests++;
      if (g_c1 !== {1'b1, 8'h00, 1'b1, 8'h55}) begin
         n_fail++;
         $display("FAIL pass_cycle1: got %h, want %h", g_c1, {1'b1, 8'h00, 1'b1, 8'h55});
      end
      n_tests++;
      if (g_done_cyc != 1281 || g_done_cnt != 1) begin
         n_fail++;
         $display("FAIL pass_done_cycle: got cycle %0d count %0d, want 1281 1", g_done_cyc,
                  g_done_cnt);
      end
      n_tests++;
      if ({bif.pass, bif.fail_addr, bif.fail_data} !== {1'b1, 8'h00, 8'h00}) begin
         n_fail++;
         $display("FAIL pass_result: got pass=%b fa=%h fd=%h, want 1 00 00", bif.pass,
                  bif.fail_addr, bif.fail_data);
      end
      n_tests++;
      if (g_busy_p1 !== 1'b0 || g_busy_p2 !== 1'b0 || g_pass_p2 !== 1'b1) begin
         n_fail++;
         $display("FAIL pass_after_done: got busy %b %b pass %b, want 0 0 1", g_busy_p1,
                  g_busy_p2, g_pass_p2);
      end
      n_tests++;
      if (g_drv_done !== 17'd0) begin
         n_fail++;
         $display("FAIL pass_done_drive: got %h, want 0", g_drv_done);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 8'hAA) bad++;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL pass_ram_contents: got %0d cells not AA, want 0", bad);
      end
   endtask

   task automatic test_fault(input int mode, input int exp_cyc, input logic [7:0] exp_addr,
                             input logic [7:0] exp_data);
      fault_mode = mode;
      do_reset();
      run(exp_cyc + 10, 0, 0, 0);
      n_tests++;
      if (g_done_cyc != exp_cyc || g_done_cnt != 1) begin
         n_fail++;
         $display("FAIL fault%0d_done_cycle: got cycle %0d count %0d, want %0d 1", mode,
                  g_done_cyc, g_done_cnt, exp_cyc);
      end
      n_tests++;
      if ({bif.pass, bif.fail_addr, bif.fail_data} !== {1'b0, exp_addr, exp_data}) begin
         n_fail++;
         $display("FAIL fault%0d_result: got pass=%b fa=%h fd=%h, want 0 %h %h", mode, bif.pass,
                  bif.fail_addr, bif.fail_data, exp_addr, exp_data);
      end
   endtask

   task automatic test_mid_reset();
      int dcnt;
      fault_mode = 0;
      do_reset();
      dcnt = 0;
      @(negedge clk);
      bif.start = 1'b1;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         bif.start = 1'b0;
      end
      n_tests++;
      if (bif.ram_write_en !== 1'b1 || bif.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_precondition: got we=%b busy=%b, want 1 1", bif.ram_write_en,
                  bif.busy);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if ({bif.busy, bif.done, bif.pass, bif.fail_addr, bif.fail_data, bif.ram_address,
           bif.ram_write_en, bif.ram_data_in} !== 35'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got busy=%b we=%b a=%h d=%h, want all 0", bif.busy,
                  bif.ram_write_en, bif.ram_address, bif.ram_data_in);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bif.done) dcnt++;
      end
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bif.done || bif.busy) dcnt++;
      end
      n_tests++;
      if (dcnt != 0) begin
         n_fail++;
         $display("FAIL midreset_no_done: got %0d done/busy cycles, want 0", dcnt);
      end
      run(1290, 0, 0, 0);
      n_tests++;
      if (g_done_cyc != 1281 || bif.pass !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_rerun: got cycle %0d pass %b, want 1281 1", g_done_cyc,
                  bif.pass);
      end
   endtask

   task automatic test_extra_start();
      fault_mode = 0;
      do_reset();
      run(1290, 5, 700, 1282);
      n_tests++;
      if (g_done_cyc != 1281 || g_done_cnt != 1) begin
         n_fail++;
         $display("FAIL extra_start_done: got cycle %0d count %0d, want 1281 1", g_done_cyc,
                  g_done_cnt);
      end
      n_tests++;
      if (g_busy_p1 !== 1'b0 || g_busy_p2 !== 1'b1 || g_pass_p2 !== 1'b0) begin
         n_fail++;
         $display("FAIL extra_start_restart: got busy %b %b pass %b, want 0 1 0", g_busy_p1,
                  g_busy_p2, g_pass_p2);
      end
      do_reset();
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      fault_mode = 0;
      reset      = 1'b1;
      bif.start  = 1'b0;
      test_reset();
      test_pass();
      test_fault(1, 291, 8'h10, 8'h54);
      test_fault(2, 323, 8'h20, 8'h57);
      test_fault(3, 515, 8'h80, 8'hAA);
      test_mid_reset();
      test_extra_start();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
